// File: rtl/ex_mdu_pkg.sv
// rtl/ex_mdu_pkg.sv - opcode/state encodings and helpers shared by the multiply/divide unit
package ex_mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MUL_LO = 2'b00,
        MDU_MUL_HI = 2'b01,
        MDU_DIVU   = 2'b10,
        MDU_REMU   = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'b00,
        MDU_CALC = 2'b01,
        MDU_DONE = 2'b10
    } mdu_state_e;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    function automatic logic is_div(input mdu_op_e op);
        return (op == MDU_DIVU) || (op == MDU_REMU);
    endfunction

endpackage

// File: rtl/mdu_divstep.sv
// rtl/mdu_divstep.sv - one combinational restoring-division step on an already shifted remainder
module mdu_divstep #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qbit
);

    logic [WIDTH-1:0] w_diff;

    // When the subtraction succeeds the difference is below the divisor, so WIDTH bits hold it.
    assign o_qbit = (i_rem >= {1'b0, i_divisor});
    assign w_diff = i_rem[WIDTH-1:0] - i_divisor;
    assign o_rem  = o_qbit ? w_diff : i_rem[WIDTH-1:0];

endmodule

// File: rtl/ex_mdu.sv
// rtl/ex_mdu.sv - multi-cycle unsigned multiply/divide unit with pipeline stall and write-back tag
module ex_mdu
    import ex_mdu_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [1:0]            op_i,
    input  logic [WIDTH-1:0]      operand1_i,
    input  logic [WIDTH-1:0]      operand2_i,
    input  logic [REG_ADDR_W-1:0] writeRegAddr_i,
    input  logic                  flush_i,
    output logic [WIDTH-1:0]      result_o,
    output logic                  valid_o,
    output logic [REG_ADDR_W-1:0] writeRegAddr_o,
    output logic                  div_by_zero_o,
    output logic                  busy_o,
    output logic                  stall_o
);

    localparam int CNT_W = $clog2(WIDTH);

    mdu_state_e              r_state;
    mdu_state_e              w_state_nxt;
    mdu_op_e                 r_op;
    mdu_op_e                 w_op_in;
    logic [CNT_W-1:0]        r_cnt;
    logic [2*WIDTH-1:0]      r_prod;
    logic [WIDTH-1:0]        r_rem;
    logic [WIDTH-1:0]        r_opnd;
    logic [WIDTH-1:0]        r_result;
    logic [REG_ADDR_W-1:0]   r_tag;
    logic [REG_ADDR_W-1:0]   r_tag_out;
    logic                    r_dbz;

    logic                    w_accept;
    logic                    w_zero_div;
    logic                    w_last;
    logic [WIDTH:0]          w_sum;
    logic [2*WIDTH-1:0]      w_prod_nxt;
    logic [WIDTH:0]          w_rem_shift;
    logic [WIDTH-1:0]        w_rem_nxt;
    logic                    w_qbit;
    logic [WIDTH-1:0]        w_quo_nxt;
    logic [WIDTH-1:0]        w_final;

    assign w_op_in    = mdu_op_e'(op_i);
    assign w_accept   = (r_state != MDU_CALC) && start_i && !flush_i;
    assign w_zero_div = is_div(w_op_in) && (operand2_i == '0);
    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

    // Multiply: multiplier sits in the low half of r_prod and shifts out as the product shifts in.
    assign w_sum      = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_opnd} : '0);
    assign w_prod_nxt = {w_sum, r_prod[WIDTH-1:1]};

    // Divide: dividend shifts out of the low half of r_prod as quotient bits shift in.
    assign w_rem_shift = {r_rem, r_prod[WIDTH-1]};
    assign w_quo_nxt   = {r_prod[WIDTH-2:0], w_qbit};

    mdu_divstep #(
        .WIDTH     (WIDTH)
    ) u_divstep (
        .i_rem     (w_rem_shift),
        .i_divisor (r_opnd),
        .o_rem     (w_rem_nxt),
        .o_qbit    (w_qbit)
    );

    always_comb begin
        w_final = w_prod_nxt[WIDTH-1:0];
        case (r_op)
            MDU_MUL_LO: w_final = w_prod_nxt[WIDTH-1:0];
            MDU_MUL_HI: w_final = w_prod_nxt[2*WIDTH-1:WIDTH];
            MDU_DIVU:   w_final = w_quo_nxt;
            MDU_REMU:   w_final = w_rem_nxt;
            default:    w_final = w_prod_nxt[WIDTH-1:0];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= MDU_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy_o      = DISABLE;
        valid_o     = DISABLE;
        stall_o     = w_accept;
        case (r_state)
            MDU_CALC: begin
                busy_o  = ENABLE;
                stall_o = ENABLE;
                if (flush_i) begin
                    w_state_nxt = MDU_IDLE;
                end else if (w_last) begin
                    w_state_nxt = MDU_DONE;
                end
            end
            default: begin
                valid_o = (r_state == MDU_DONE);
                if (w_accept) begin
                    w_state_nxt = w_zero_div ? MDU_DONE : MDU_CALC;
                end else begin
                    w_state_nxt = MDU_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op      <= MDU_MUL_LO;
            r_cnt     <= '0;
            r_prod    <= '0;
            r_rem     <= '0;
            r_opnd    <= '0;
            r_result  <= '0;
            r_tag     <= '0;
            r_tag_out <= '0;
            r_dbz     <= DISABLE;
        end else if (w_accept) begin
            r_op  <= w_op_in;
            r_tag <= writeRegAddr_i;
            r_cnt <= '0;
            r_rem <= '0;
            r_dbz <= w_zero_div;
            if (is_div(w_op_in)) begin
                r_opnd <= operand2_i;
                r_prod <= {{WIDTH{1'b0}}, operand1_i};
            end else begin
                r_opnd <= operand1_i;
                r_prod <= {{WIDTH{1'b0}}, operand2_i};
            end
            if (w_zero_div) begin
                r_result  <= (w_op_in == MDU_DIVU) ? '1 : operand1_i;
                r_tag_out <= writeRegAddr_i;
            end
        end else if ((r_state == MDU_CALC) && !flush_i) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (is_div(r_op)) begin
                r_rem               <= w_rem_nxt;
                r_prod[WIDTH-1:0]   <= w_quo_nxt;
            end else begin
                r_prod <= w_prod_nxt;
            end
            if (w_last) begin
                r_result  <= w_final;
                r_tag_out <= r_tag;
            end
        end
    end

    assign result_o       = r_result;
    assign writeRegAddr_o = r_tag_out;
    assign div_by_zero_o  = r_dbz && (r_state == MDU_DONE);

endmodule
